ks_data_path_param: RTL

//  Parametrised K&S datapath: PC, instruction register, NREGS-entry register file, 4-op ALU, flags register.

---
 rtl/ks_data_path_param_pkg.sv | 57 +++++
 rtl/ks_data_path_param_if.sv | 39 +++
 rtl/ks_data_path_param_alu.sv | 46 ++++
 rtl/ks_data_path_param.sv | 114 +++++++++++
 4 files changed

// File: rtl/ks_data_path_param_pkg.sv
// Shared types for the K&S datapath: instruction decode enum, opcodes, ALU ops.
package k_and_s_pkg;

  typedef enum logic [3:0] {
    I_NOP, I_BRANCH, I_BZERO, I_BNEG, I_BOV, I_BNOV, I_BNNEG, I_BNZERO,
    I_LOAD, I_STORE, I_MOVE, I_ADD, I_SUB, I_AND, I_OR, I_HALT
  } decoded_instruction_type;

  typedef enum logic [1:0] {
    ALU_ADD = 2'b00,
    ALU_SUB = 2'b01,
    ALU_AND = 2'b10,
    ALU_OR  = 2'b11
  } alu_op_t;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_BRANCH = 8'h01;
  localparam logic [7:0] OP_BZERO  = 8'h02;
  localparam logic [7:0] OP_BNEG   = 8'h03;
  localparam logic [7:0] OP_BOV    = 8'h05;
  localparam logic [7:0] OP_BNOV   = 8'h06;
  localparam logic [7:0] OP_BNNEG  = 8'h0A;
  localparam logic [7:0] OP_BNZERO = 8'h0B;
  localparam logic [7:0] OP_LOAD   = 8'h81;
  localparam logic [7:0] OP_STORE  = 8'h82;
  localparam logic [7:0] OP_MOVE   = 8'h91;
  localparam logic [7:0] OP_ADD    = 8'hA1;
  localparam logic [7:0] OP_SUB    = 8'hA2;
  localparam logic [7:0] OP_AND    = 8'hA3;
  localparam logic [7:0] OP_OR     = 8'hA4;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  // Unknown opcodes fall back to NOP so a corrupt fetch never stalls the sequencer.
  function automatic decoded_instruction_type decode_opcode(input logic [7:0] opc);
    decoded_instruction_type d;
    case (opc)
      OP_BRANCH: d = I_BRANCH;
      OP_BZERO:  d = I_BZERO;
      OP_BNEG:   d = I_BNEG;
      OP_BOV:    d = I_BOV;
      OP_BNOV:   d = I_BNOV;
      OP_BNNEG:  d = I_BNNEG;
      OP_BNZERO: d = I_BNZERO;
      OP_LOAD:   d = I_LOAD;
      OP_STORE:  d = I_STORE;
      OP_MOVE:   d = I_MOVE;
      OP_ADD:    d = I_ADD;
      OP_SUB:    d = I_SUB;
      OP_AND:    d = I_AND;
      OP_OR:     d = I_OR;
      OP_HALT:   d = I_HALT;
      default:   d = I_NOP;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/ks_data_path_param_if.sv
// Control-unit / RAM side bundle for the K&S datapath.
interface ks_data_path_param_if
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5
);
  logic                    branch;
  logic                    pc_enable;
  logic                    ir_enable;
  logic                    addr_sel;
  logic                    c_sel;
  alu_op_t                 operation;
  logic                    write_reg_enable;
  logic                    flags_reg_enable;
  decoded_instruction_type decoded_instruction;
  logic                    zero_op;
  logic                    neg_op;
  logic                    unsigned_overflow;
  logic                    signed_overflow;
  logic [ADDR_W-1:0]       ram_addr;
  logic [DATA_W-1:0]       data_out;
  logic [DATA_W-1:0]       data_in;

  // master: control unit plus RAM read port; slave: the datapath
  modport master (
    output branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
    output write_reg_enable, flags_reg_enable, data_in,
    input  decoded_instruction, zero_op, neg_op, unsigned_overflow,
    input  signed_overflow, ram_addr, data_out
  );

  modport slave (
    input  branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
    input  write_reg_enable, flags_reg_enable, data_in,
    output decoded_instruction, zero_op, neg_op, unsigned_overflow,
    output signed_overflow, ram_addr, data_out
  );
endinterface

// File: rtl/ks_data_path_param_alu.sv
// Combinational 4-op ALU with zero/sign/carry-borrow/overflow flags.
module ks_alu
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_t           op,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              neg,
  output logic              uov,
  output logic              sov
);
  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra bit of the widened subtraction is the unsigned borrow (a < b).
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    uov    = 1'b0;
    sov    = 1'b0;
    case (op)
      ALU_ADD: begin
        result = sum[DATA_W-1:0];
        uov    = sum[DATA_W];
        sov    = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        result = diff[DATA_W-1:0];
        uov    = diff[DATA_W];
        sov    = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: result = a & b;
      ALU_OR:  result = a | b;
      default: result = '0;
    endcase
  end

  assign zero = (result == '0);
  assign neg  = result[DATA_W-1];
endmodule

// File: rtl/ks_data_path_param.sv
// Parametrised K&S datapath: PC, IR, register file, ALU and registered flags,
// sequenced by an external control unit over the slave modport.
module ks_data_path_param
  import k_and_s_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 4
) (
  input logic                  clk,
  input logic                  rst_n,
  ks_data_path_param_if.slave  bus
);
  localparam int RW = $clog2(NREGS);

  logic [ADDR_W-1:0] pc_reg;
  logic [DATA_W-1:0] ir_reg;
  logic [DATA_W-1:0] regs_reg [NREGS];
  logic              zero_reg, neg_reg, uov_reg, sov_reg;

  decoded_instruction_type dec;
  logic [RW-1:0]     a_addr, b_addr, c_addr;
  logic [RW-1:0]     mem_reg;
  logic [ADDR_W-1:0] mem_addr;
  logic              b_zero;
  logic [DATA_W-1:0] bus_a, bus_b, bus_c, alu_result;
  logic              alu_zero, alu_neg, alu_uov, alu_sov;
  logic [NREGS-1:0]  reg_we;
  logic              unused_ir_bits;

  assign dec      = decode_opcode(ir_reg[DATA_W-1 -: 8]);
  assign mem_reg  = ir_reg[ADDR_W+RW-1:ADDR_W];
  assign mem_addr = ir_reg[ADDR_W-1:0];
  // Not every IR bit feeds a field in every format; fold them to keep them referenced.
  assign unused_ir_bits = ^ir_reg;

  always_comb begin
    a_addr = ir_reg[3*RW-1:2*RW];
    b_addr = ir_reg[2*RW-1:RW];
    c_addr = ir_reg[RW-1:0];
    b_zero = 1'b0;
    case (dec)
      I_LOAD:  c_addr = mem_reg;
      I_STORE: a_addr = mem_reg;
      I_MOVE:  b_zero = 1'b1;
      default: ;
    endcase
  end

  assign bus_a = regs_reg[a_addr];
  assign bus_b = b_zero ? '0 : regs_reg[b_addr];
  assign bus_c = bus.c_sel ? bus.data_in : alu_result;

  ks_alu #(.DATA_W(DATA_W)) u_alu (
    .a      (bus_a),
    .b      (bus_b),
    .op     (bus.operation),
    .result (alu_result),
    .zero   (alu_zero),
    .neg    (alu_neg),
    .uov    (alu_uov),
    .sov    (alu_sov)
  );

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_we
      assign reg_we[gi] = bus.write_reg_enable && (c_addr == RW'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (reg_we[i]) regs_reg[i] <= bus_c;
      end
    end
  end

  // Branch target comes from the pre-edge IR even when IR loads on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_reg <= '0;
      ir_reg <= '0;
    end else begin
      if (bus.pc_enable) pc_reg <= bus.branch ? mem_addr : pc_reg + 1'b1;
      if (bus.ir_enable) ir_reg <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
      neg_reg  <= 1'b0;
      uov_reg  <= 1'b0;
      sov_reg  <= 1'b0;
    end else if (bus.flags_reg_enable) begin
      zero_reg <= alu_zero;
      neg_reg  <= alu_neg;
      uov_reg  <= alu_uov;
      sov_reg  <= alu_sov;
    end
  end

  assign bus.decoded_instruction = dec;
  assign bus.zero_op             = zero_reg;
  assign bus.neg_op              = neg_reg;
  assign bus.unsigned_overflow   = uov_reg;
  assign bus.signed_overflow     = sov_reg;
  assign bus.ram_addr            = bus.addr_sel ? mem_addr : pc_reg;
  assign bus.data_out            = bus_a;
endmodule
